// File: rtl/zbt_sched.sv
// ----------------------------------------------------------------------------
// zbt_sched : arbitrates display reads and capture/processed writes onto a ZBT SRAM
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module zbt_sched #(
  parameter int STARVE_MAX = 8,
  parameter int RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_req,
  input  logic [18:0] disp_addr,
  output logic        disp_gnt,
  output logic [35:0] disp_rdata,
  output logic        disp_rvalid,
  input  logic        cap_req,
  input  logic [18:0] cap_addr,
  input  logic [35:0] cap_wdata,
  output logic        cap_gnt,
  input  logic        proc_req,
  input  logic [18:0] proc_addr,
  input  logic [35:0] proc_wdata,
  output logic        proc_gnt,
  input  logic        halt,
  output logic        halted,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [35:0] mem_wdata,
  input  logic [35:0] mem_rdata
);

  localparam int c_wcw = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_wcw-1:0] c_starve = c_wcw'(STARVE_MAX);

  localparam logic [1:0] c_run    = 2'd0;
  localparam logic [1:0] c_drain  = 2'd1;
  localparam logic [1:0] c_halted = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [c_wcw-1:0] r_wait;
  logic             w_wr_ok;
  logic             w_proc_first;
  logic             w_disp_x;
  logic             w_cap_x;
  logic             w_proc_x;
  logic             r_wv0;
  logic             r_wv1;
  logic [35:0]      r_wd0;
  logic [35:0]      r_wd1;
  logic [RD_LAT:0]  r_rv;

  // Writes are gated by halt and state; display reads never are.
  always_comb begin
    w_wr_ok      = reset && !halt && (r_state == c_run);
    w_proc_first = (r_wait == c_starve);
    disp_gnt     = reset && disp_req;
    proc_gnt     = w_wr_ok && !disp_req && proc_req && (w_proc_first || !cap_req);
    cap_gnt      = w_wr_ok && !disp_req && cap_req && !(w_proc_first && proc_req);
    w_disp_x     = disp_req && disp_gnt;
    w_cap_x      = cap_req && cap_gnt;
    w_proc_x     = proc_req && proc_gnt;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_run:    if (halt) w_next_state = c_drain;
      c_drain: begin
        if (!halt)                w_next_state = c_run;
        else if (!(r_wv0 || r_wv1)) w_next_state = c_halted;
      end
      c_halted: if (!halt) w_next_state = c_run;
      default:  w_next_state = c_run;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_run;
      halted  <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next_state;
      halted  <= (w_next_state == c_halted);
      if (proc_req && !w_proc_x) begin
        if (r_wait != c_starve) r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= '0;
      mem_we   <= 1'b0;
    end else begin
      mem_we <= w_cap_x || w_proc_x;
      if (w_disp_x)      mem_addr <= disp_addr;
      else if (w_cap_x)  mem_addr <= cap_addr;
      else if (w_proc_x) mem_addr <= proc_addr;
    end
  end

  // Two-stage write data delay so mem_wdata trails mem_we by two cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wv0     <= 1'b0;
      r_wv1     <= 1'b0;
      r_wd0     <= '0;
      r_wd1     <= '0;
      mem_wdata <= '0;
    end else begin
      r_wv0 <= w_cap_x || w_proc_x;
      r_wv1 <= r_wv0;
      if (w_cap_x)       r_wd0 <= cap_wdata;
      else if (w_proc_x) r_wd0 <= proc_wdata;
      if (r_wv0) r_wd1     <= r_wd0;
      if (r_wv1) mem_wdata <= r_wd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rv        <= '0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
    end else begin
      r_rv[0] <= w_disp_x;
      for (int i = 1; i <= RD_LAT; i++) r_rv[i] <= r_rv[i-1];
      disp_rvalid <= r_rv[RD_LAT];
      if (r_rv[RD_LAT]) disp_rdata <= mem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zbt_sched.sv
// ----------------------------------------------------------------------------
// tb_zbt_sched : vector table, directed corner sequences and random traffic
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_zbt_sched;

  localparam int SM = 8;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req, cap_req, proc_req, halt;
  logic [18:0] disp_addr, cap_addr, proc_addr;
  logic [35:0] cap_wdata, proc_wdata, mem_rdata;
  logic        disp_gnt, cap_gnt, proc_gnt, disp_rvalid, halted, mem_we;
  logic [35:0] disp_rdata, mem_wdata;
  logic [18:0] mem_addr;

  always #5 clk = ~clk;

  zbt_sched #(.STARVE_MAX(SM), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .cap_req(cap_req), .cap_addr(cap_addr), .cap_wdata(cap_wdata), .cap_gnt(cap_gnt),
    .proc_req(proc_req), .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_gnt(proc_gnt),
    .halt(halt), .halted(halted),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_edge = 0;

  // Reference model: pending transfers are kept as due-time queues.
  typedef struct { logic [35:0] data; int due; } wr_t;
  wr_t wq[$];
  int  rq[$];
  int          m_state;  // 0 run, 1 drain, 2 halted
  int          m_wait;
  logic [18:0] m_addr;
  logic        m_we, m_rvalid, m_halted;
  logic [35:0] m_wdata, m_rdata;

  typedef struct { bit d, c, p, h; bit ed, ec, ep; } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] rnd36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[35:0];
  endfunction

  function automatic logic [18:0] rnd19();
    logic [31:0] t;
    t = $urandom();
    return t[18:0];
  endfunction

  // 0 none, 1 disp, 2 cap, 3 proc
  function automatic int winner();
    if (!reset) return 0;
    if (disp_req) return 1;
    if (halt || m_state != 0) return 0;
    if (proc_req && (m_wait == SM || !cap_req)) return 3;
    if (cap_req) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    m_state = 0; m_wait = 0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
    m_rdata = '0; m_rvalid = 1'b0; m_halted = 1'b0;
    wq.delete();
    rq.delete();
  endtask

  task automatic model_edge(input int w);
    bit  busy;
    wr_t e;
    busy = (wq.size() != 0);
    if (busy && wq[0].due == n_edge) begin
      m_wdata = wq[0].data;
      void'(wq.pop_front());
    end
    m_rvalid = 1'b0;
    if (rq.size() != 0 && rq[0] == n_edge) begin
      m_rdata  = mem_rdata;
      m_rvalid = 1'b1;
      void'(rq.pop_front());
    end
    case (m_state)
      0: if (halt) m_state = 1;
      1: if (!halt) m_state = 0; else if (!busy) m_state = 2;
      default: if (!halt) m_state = 0;
    endcase
    m_halted = (m_state == 2);
    if (proc_req && w != 3) m_wait = (m_wait < SM) ? m_wait + 1 : SM;
    else m_wait = 0;
    m_we = (w == 2 || w == 3);
    case (w)
      1: begin m_addr = disp_addr; rq.push_back(n_edge + 1 + RL); end
      2: begin m_addr = cap_addr;  e.data = cap_wdata;  e.due = n_edge + 2; wq.push_back(e); end
      3: begin m_addr = proc_addr; e.data = proc_wdata; e.due = n_edge + 2; wq.push_back(e); end
      default: ;
    endcase
  endtask

  // One clock: check grants against the model, take the edge, check registered outputs.
  task automatic cycle();
    int w;
    #1;
    if (!reset) model_clear();
    w = winner();
    chk("disp_gnt", disp_gnt, w == 1);
    chk("cap_gnt",  cap_gnt,  w == 2);
    chk("proc_gnt", proc_gnt, w == 3);
    @(posedge clk);
    #1;
    if (reset) model_edge(w); else model_clear();
    n_edge++;
    chk("mem_addr",    mem_addr,    m_addr);
    chk("mem_we",      mem_we,      m_we);
    chk("mem_wdata",   mem_wdata,   m_wdata);
    chk("disp_rdata",  disp_rdata,  m_rdata);
    chk("disp_rvalid", disp_rvalid, m_rvalid);
    chk("halted",      halted,      m_halted);
  endtask

  task automatic idle();
    disp_req = 0; cap_req = 0; proc_req = 0; halt = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle();
    cycle();
    cycle();
    reset = 1;
  endtask

  initial begin
    reset = 0; mem_rdata = '0;
    disp_addr = '0; cap_addr = '0; proc_addr = '0; cap_wdata = '0; proc_wdata = '0;
    idle();
    model_clear();
    do_reset();
    chk("rst_halted", halted, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);

    // Grant table from RUN with a fresh starvation counter
    tv[0] = '{0,0,0,0, 0,0,0};
    tv[1] = '{1,1,1,0, 1,0,0};
    tv[2] = '{0,1,1,0, 0,1,0};
    tv[3] = '{0,0,1,0, 0,0,1};
    tv[4] = '{1,0,0,0, 1,0,0};
    tv[5] = '{0,1,0,0, 0,1,0};
    tv[6] = '{1,0,1,1, 1,0,0};
    tv[7] = '{0,1,1,1, 0,0,0};
    for (int i = 0; i < 8; i++) begin
      disp_req = tv[i].d; cap_req = tv[i].c; proc_req = tv[i].p; halt = tv[i].h;
      disp_addr = rnd19(); cap_addr = rnd19(); proc_addr = rnd19();
      cap_wdata = rnd36(); proc_wdata = rnd36();
      #1;
      chk($sformatf("tv%0d_disp", i), disp_gnt, tv[i].ed);
      chk($sformatf("tv%0d_cap", i),  cap_gnt,  tv[i].ec);
      chk($sformatf("tv%0d_proc", i), proc_gnt, tv[i].ep);
      cycle();
    end

    // Read latency: address at E, data sampled at E+3
    do_reset();
    disp_req = 1; disp_addr = 19'h00010;
    cycle();
    chk("rd_addr", mem_addr, 19'h00010);
    chk("rd_we", mem_we, 1'b0);
    idle();
    cycle();
    cycle();
    mem_rdata = 36'hABCDE1234;
    cycle();
    chk("rd_data", disp_rdata, 36'hABCDE1234);
    chk("rd_valid", disp_rvalid, 1'b1);
    mem_rdata = '0;
    cycle();
    chk("rd_valid_pulse", disp_rvalid, 1'b0);

    // Starvation: proc overtakes cap after STARVE_MAX losses
    do_reset();
    cap_req = 1; proc_req = 1;
    for (int i = 0; i < SM; i++) begin
      #1;
      chk($sformatf("starve%0d_cap", i), cap_gnt, 1'b1);
      cycle();
    end
    #1;
    chk("starve_proc", proc_gnt, 1'b1);
    chk("starve_cap", cap_gnt, 1'b0);
    cycle();
    #1;
    chk("starve_clr_cap", cap_gnt, 1'b1);
    cycle();

    // Write addressing and data delay at the top address
    do_reset();
    proc_req = 1; proc_addr = 19'h7FFFF; proc_wdata = 36'h123456789;
    cycle();
    chk("wr_addr", mem_addr, 19'h7FFFF);
    chk("wr_we", mem_we, 1'b1);
    idle();
    cycle();
    chk("wr_we_drop", mem_we, 1'b0);
    cycle();
    chk("wr_data", mem_wdata, 36'h123456789);

    // Halt with a write in flight
    do_reset();
    cap_req = 1; cap_addr = 19'h00123; cap_wdata = 36'h0CAFE0001;
    cycle();
    halt = 1; disp_req = 1; proc_req = 1;
    #1;
    chk("halt_disp_gnt", disp_gnt, 1'b1);
    chk("halt_cap_gnt", cap_gnt, 1'b0);
    cycle();
    chk("halt_e1", halted, 1'b0);
    disp_req = 0;
    #1;
    chk("halt_cap_gnt2", cap_gnt, 1'b0);
    cycle();
    chk("halt_e2", halted, 1'b0);
    chk("halt_drain_data", mem_wdata, 36'h0CAFE0001);
    cycle();
    chk("halt_e3", halted, 1'b1);
    halt = 0;
    cycle();
    chk("unhalt", halted, 1'b0);
    #1;
    chk("unhalt_cap_gnt", cap_gnt, 1'b1);
    cycle();

    // Reset one cycle after a read accept drops the read
    do_reset();
    disp_req = 1; disp_addr = 19'h00042;
    cycle();
    reset = 0; disp_req = 0;
    #1;
    chk("rst_mid_addr", mem_addr, 19'h0);
    chk("rst_mid_disp_gnt", disp_gnt, 1'b0);
    cycle();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = rnd36();
      cycle();
      chk($sformatf("rst_no_rvalid%0d", i), disp_rvalid, 1'b0);
    end
    cap_req = 1;
    #1;
    chk("rst_resume_gnt", cap_gnt, 1'b1);
    cycle();
    chk("rst_resume_we", mem_we, 1'b1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      disp_req  = ($urandom_range(99) < 30);
      cap_req   = ($urandom_range(99) < 55);
      proc_req  = ($urandom_range(99) < 55);
      if ($urandom_range(99) < 8) halt = ~halt;
      disp_addr = rnd19(); cap_addr = rnd19(); proc_addr = rnd19();
      cap_wdata = rnd36(); proc_wdata = rnd36(); mem_rdata = rnd36();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zbt_sched.md
ZBT_SCHED -- requirements
Module: zbt_sched

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8: proc wait cycles before proc outranks cap.
REQ-002 SHALL have parameter RD_LAT, default 2: ZBT read latency, in cycles, from the address edge.
REQ-003 clk  input  1  single clock for all logic; all registers update on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 disp_req  input  1  display read request.
REQ-006 disp_addr  input  19  display read address.
REQ-007 disp_gnt  output  1  combinational accept for the display request.
REQ-008 disp_rdata  output  36  returned two-pixel word.
REQ-009 disp_rvalid  output  1  disp_rdata valid, one-cycle pulse per read.
REQ-010 cap_req  input  1  capture write request.
REQ-011 cap_addr  input  19  capture write address.
REQ-012 cap_wdata  input  36  capture write data.
REQ-013 cap_gnt  output  1  combinational accept for the capture request.
REQ-014 proc_req  input  1  processed-pixel write request.
REQ-015 proc_addr  input  19  processed-pixel write address.
REQ-016 proc_wdata  input  36  processed-pixel write data.
REQ-017 proc_gnt  output  1  combinational accept for the processed-pixel request.
REQ-018 halt  input  1  level request to stop granting writes.
REQ-019 halted  output  1  all writes blocked and the write pipeline is empty.
REQ-020 mem_addr  output  19  ZBT address, registered.
REQ-021 mem_we  output  1  ZBT write enable, active-high, registered.
REQ-022 mem_wdata  output  36  ZBT write data, registered.
REQ-023 mem_rdata  input  36  ZBT read data.

Function
REQ-024 A transfer SHALL occur at a posedge where x_req=1 and x_gnt=1; at most one gnt SHALL be high per cycle.
REQ-025 Priority SHALL be disp > cap > proc, except that proc SHALL outrank cap (never disp) when wait_cnt==STARVE_MAX.
REQ-026 cap_gnt and proc_gnt SHALL be 0 whenever halt=1 or state!=RUN; disp_gnt SHALL depend only on disp_req.
REQ-027 wait_cnt SHALL increment, saturating at STARVE_MAX, each cycle proc_req=1 and proc_gnt=0.
REQ-028 wait_cnt SHALL clear when a proc transfer occurs or when proc_req=0.
REQ-029 On a transfer at edge E, mem_addr and mem_we (1 for write, 0 for read) SHALL update at E; mem_we SHALL be 0 in cycles with no transfer, and mem_addr SHALL hold its last value.
REQ-030 Write data SHALL be registered at E and delayed so mem_wdata updates at edge E+2; mem_wdata SHALL hold when no write is in flight.
REQ-031 For a read at E, mem_rdata SHALL be captured into disp_rdata at edge E+1+RD_LAT, with disp_rvalid=1 for exactly the following cycle.
REQ-032 Back-to-back transfers SHALL be supported every cycle; the read and write pipelines SHALL be independent shift registers with no bubbles.
REQ-033 FSM RUN -> DRAIN SHALL occur when halt=1 is sampled.
REQ-034 FSM DRAIN -> HALTED SHALL occur when no write is in flight (write-delay pipe empty).
REQ-035 FSM DRAIN -> RUN SHALL occur if halt=0 is sampled (abort); this transition takes precedence over DRAIN -> HALTED.
REQ-036 FSM HALTED -> RUN SHALL occur when halt=0 is sampled.
REQ-037 halted SHALL be 1 iff state==HALTED (registered).
REQ-038 Display reads SHALL continue in every state.

Reset
REQ-039 While reset=0, all outputs except the gnt signals SHALL be 0, state SHALL be RUN, wait_cnt SHALL be 0, and all pipeline valid bits SHALL be cleared.
REQ-040 The gnt signals SHALL be forced to 0 while reset=0.
REQ-041 Reset asserted mid-operation SHALL discard in-flight reads (no disp_rvalid) and writes (no further mem_wdata update).

Verification
REQ-042 disp_req=1, cap_req=1, proc_req=1 in one cycle -> only disp_gnt=1; cap is granted next cycle once disp_req drops.
REQ-043 disp read addr 0x00010 at edge E, mem_rdata=0xABCDE1234 at E+3 -> disp_rdata=0xABCDE1234 and disp_rvalid=1 for one cycle after E+3.
REQ-044 cap_req held high, proc_req high for 8 ungranted cycles (STARVE_MAX=8) -> 9th cycle proc_gnt=1, cap_gnt=0, wait_cnt then clears.
REQ-045 proc write addr 0x7FFFF, data 0x123456789 at E -> mem_addr=0x7FFFF, mem_we=1 after E; mem_wdata=0x123456789 after E+2.
REQ-046 Write accepted at E, halt=1 sampled at E+1 -> cap/proc gnt=0 from E+1, halted=1 after the write drains at E+2 (visible from E+3); disp reads are still granted.
REQ-047 reset=0 pulsed one cycle after a read accept -> no disp_rvalid pulse, all outputs 0, and the block resumes in RUN.
